// File: rtl/register_bank_pkg.sv
// Shared constants and types for the 32-entry register bank.
package register_bank_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Address 0 is the hard-wired zero register.
  function automatic logic addr_is_zero(input reg_addr_t a);
    return (a == 5'd0);
  endfunction

endpackage

// File: rtl/register_bank_decoder5x32.sv
// decoder5x32: 5-bit binary address to 32-bit one-hot select.
module decoder5x32
  import register_bank_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  output logic [NREGS-1:0]  y
);

  // One-hot decode: exactly one select line high for every address.
  always_comb begin
    y    = 32'd0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: 32 x DATA_W register file, one write port, two
// combinational read ports. Register 0 is hard-wired to zero.
// Synchronous active-low reset clears every register.
// Optional macro REGISTER_BANK_BYPASS_EN forwards the pending write data
// to a read port that addresses the register being written.
module register_bank #(
  parameter int DATA_W = register_bank_pkg::DATA_W,
  parameter int NREGS  = register_bank_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  import register_bank_pkg::*;

  // Slot 0 never accepts a write, so its select bit is masked off.
  localparam logic [NREGS-1:0] STORE_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0]  sel_s;
  logic [NREGS-1:0]  wr_en_s;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  decoder5x32 u_dec (
    .a (wa),
    .y (sel_s)
  );

  // Per-register load enable: one-hot select qualified by we, slot 0 excluded.
  always_comb begin
    wr_en_s = sel_s & STORE_MASK & {NREGS{we}};
  end

  // Next-state: at most one register takes wd, all others hold.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en_s[i]) begin
        regs_d[i] = wd;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  // Read ports with same-cycle forwarding of a live, non-zero-address write.
  always_comb begin
    if (we && rst && !addr_is_zero(wa) && (ra1 == wa)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_q[ra1];
    end
    if (we && rst && !addr_is_zero(wa) && (ra2 == wa)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_q[ra2];
    end
  end
`else
  // Read ports return stored contents only; new data appears after the edge.
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
  end
`endif

endmodule
